// File: rtl/crack_pkg.sv
// Shared types and constants for the arc4 key-search controller.
// The printable-ASCII test lives here so every block agrees on what counts as a passing byte.
package crack_pkg;

    typedef enum logic [3:0] {
        IDLE,
        A4_RESET,
        A4_START,
        A4_WAIT,
        LEN_RD,
        LEN_WAIT,
        SCAN,
        NEXT_KEY,
        DONE
    } crack_state_t;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_LEN_RD,
        PS_LEN_WAIT,
        PS_SCAN
    } scan_state_t;

    localparam logic [23:0] KEY_MAX  = 24'hFFFFFF;
    localparam logic [7:0]  ASCII_LO = 8'h20;
    localparam logic [7:0]  ASCII_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_LO) && (b <= ASCII_HI);
    endfunction

endpackage

// File: rtl/crack_ctrl_if.sv
// Host-side start/result handshake of the key-search controller.
interface crack_ctrl_if;

    logic        en;
    logic        rdy;
    logic        key_valid;
    logic [23:0] key;

    modport master (output en, input rdy, input key_valid, input key);
    modport slave  (input en, output rdy, output key_valid, output key);

endinterface

// File: rtl/crack_ctrl_pt_scan.sv
// Reads the length byte at address 0, then streams addresses 1..len and checks each
// returned byte one cycle later; reports pass/fail on the cycle the verdict is known.
module pt_scan
    import crack_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic       done,
    output logic       pass,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata
);

    scan_state_t state;
    logic [7:0]  len;
    logic [8:0]  idx;
    logic [8:0]  idx_nxt;
    logic        byte_due;
    logic        byte_ok;
    logic        last;

    // idx is the address on the bus; the byte for idx-1 is on pt_rddata this cycle.
    // Nine bits so that len=255 can reach 256 without wrapping.
    always_comb begin
        idx_nxt  = idx + 9'd1;
        byte_due = (state == PS_SCAN) && (idx >= 9'd2);
        byte_ok  = is_printable(pt_rddata);
        last     = (idx == ({1'b0, len} + 9'd1));
        done     = 1'b0;
        pass     = 1'b0;
        if ((state == PS_LEN_WAIT) && (pt_rddata == 8'd0)) begin
            done = 1'b1;
            pass = 1'b1;
        end else if (state == PS_SCAN) begin
            if (byte_due && !byte_ok) begin
                done = 1'b1;
            end else if (last) begin
                done = 1'b1;
                pass = 1'b1;
            end
        end
    end

    assign rdy = (state == PS_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PS_IDLE;
            len     <= 8'd0;
            idx     <= 9'd0;
            pt_addr <= 8'd0;
        end else begin
            case (state)
                PS_IDLE: begin
                    if (en) state <= PS_LEN_RD;
                end
                PS_LEN_RD: begin
                    state <= PS_LEN_WAIT;
                end
                PS_LEN_WAIT: begin
                    len <= pt_rddata;
                    if (pt_rddata == 8'd0) begin
                        state <= PS_IDLE;
                    end else begin
                        state   <= PS_SCAN;
                        idx     <= 9'd1;
                        pt_addr <= 8'd1;
                    end
                end
                PS_SCAN: begin
                    // A failing byte drops the address immediately; the read already issued is ignored.
                    if (done) begin
                        state   <= PS_IDLE;
                        pt_addr <= 8'd0;
                    end else begin
                        idx     <= idx_nxt;
                        pt_addr <= (idx_nxt <= {1'b0, len}) ? idx_nxt[7:0] : 8'd0;
                    end
                end
                default: state <= PS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/crack_ctrl.sv
// Brute-force arc4 key search: restarts the arc4 core for each candidate key and accepts
// the first key whose decrypted plaintext is entirely printable ASCII.
module crack_ctrl
    import crack_pkg::*;
#(
    parameter logic [23:0] CAND_INIT = 24'h000000
)
(
    input  logic         clk,
    input  logic         rst_n,
    crack_ctrl_if.slave  host,
    output logic         a4_rst_n,
    output logic         a4_en,
    output logic [23:0]  a4_key,
    input  logic         a4_rdy,
    output logic [7:0]   pt_addr,
    input  logic [7:0]   pt_rddata
);

    crack_state_t state;
    logic [23:0]  cand;
    logic         rdy_q;
    logic         key_valid_q;
    logic [23:0]  key_q;
    logic         scan_en;
    logic         scan_rdy;
    logic         scan_done;
    logic         scan_pass;

    assign host.rdy       = rdy_q;
    assign host.key_valid = key_valid_q;
    assign host.key       = key_q;

    // The scanner leaves idle on the same edge that moves this FSM into LEN_RD.
    assign scan_en = (state == A4_WAIT) && a4_rdy && scan_rdy;

    pt_scan u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (scan_en),
        .rdy       (scan_rdy),
        .done      (scan_done),
        .pass      (scan_pass),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cand        <= 24'd0;
            rdy_q       <= 1'b1;
            key_valid_q <= 1'b0;
            key_q       <= 24'd0;
            a4_rst_n    <= 1'b1;
            a4_en       <= 1'b0;
            a4_key      <= 24'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (host.en) begin
                        cand        <= CAND_INIT;
                        a4_key      <= CAND_INIT;
                        key_valid_q <= 1'b0;
                        rdy_q       <= 1'b0;
                        a4_rst_n    <= 1'b0;
                        state       <= A4_RESET;
                    end
                end
                A4_RESET: begin
                    a4_rst_n <= 1'b1;
                    a4_en    <= 1'b1;
                    state    <= A4_START;
                end
                A4_START: begin
                    a4_en <= 1'b0;
                    state <= A4_WAIT;
                end
                A4_WAIT: begin
                    if (scan_en) state <= LEN_RD;
                end
                LEN_RD: begin
                    state <= LEN_WAIT;
                end
                LEN_WAIT: begin
                    if (scan_done) begin
                        state       <= DONE;
                        rdy_q       <= 1'b1;
                        key_valid_q <= 1'b1;
                        key_q       <= cand;
                    end else begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_done) begin
                        if (scan_pass) begin
                            state       <= DONE;
                            rdy_q       <= 1'b1;
                            key_valid_q <= 1'b1;
                            key_q       <= cand;
                        end else begin
                            state <= NEXT_KEY;
                        end
                    end
                end
                NEXT_KEY: begin
                    // Exhausting the key space ends the search rather than wrapping to zero.
                    if (cand == KEY_MAX) begin
                        state       <= DONE;
                        rdy_q       <= 1'b1;
                        key_valid_q <= 1'b0;
                        key_q       <= 24'd0;
                    end else begin
                        cand     <= cand + 24'd1;
                        a4_key   <= cand + 24'd1;
                        a4_rst_n <= 1'b0;
                        state    <= A4_RESET;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crack_ctrl.sv
// Directed bench for crack_ctrl with a behavioural arc4 core and plaintext memory whose
// contents depend on the key the core was started with.
module tb_crack_ctrl;

    logic        clk;
    logic        rst_n;
    int          tests_run;
    int          fails;

    crack_ctrl_if h1 ();
    crack_ctrl_if h2 ();

    logic        a4_rst_n, a4_en, a4_rdy, a4_hold;
    logic [23:0] a4_key, model_key, good_key;
    logic [7:0]  pt_addr, pt_rddata;
    logic [2:0]  a4_cnt;
    logic [7:0]  good_mem [256];
    logic [7:0]  bad_mem  [256];

    logic        a4_rst_n2, a4_en2, a4_rdy2;
    logic [23:0] a4_key2, model_key2, good_key2;
    logic [7:0]  pt_addr2, pt_rddata2;

    logic        clr_mon;
    int          rst_pulses, en_pulses, rst_pulses2;
    logic [7:0]  max_addr, max_bad_addr;

    crack_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (h1),
        .a4_rst_n  (a4_rst_n),
        .a4_en     (a4_en),
        .a4_key    (a4_key),
        .a4_rdy    (a4_rdy),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata)
    );

    crack_ctrl #(.CAND_INIT(24'hFFFFFE)) dut_top (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (h2),
        .a4_rst_n  (a4_rst_n2),
        .a4_en     (a4_en2),
        .a4_key    (a4_key2),
        .a4_rdy    (a4_rdy2),
        .pt_addr   (pt_addr2),
        .pt_rddata (pt_rddata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // arc4 core model: done a few cycles after its start pulse, cleared by its restart
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a4_rdy    <= 1'b0;
            a4_cnt    <= 3'd0;
            model_key <= 24'd0;
        end else if (!a4_rst_n) begin
            a4_rdy <= 1'b0;
            a4_cnt <= 3'd0;
        end else if (a4_en) begin
            model_key <= a4_key;
            a4_cnt    <= 3'd3;
        end else if (a4_cnt != 3'd0) begin
            a4_cnt <= a4_cnt - 3'd1;
            if (a4_cnt == 3'd1 && !a4_hold) a4_rdy <= 1'b1;
        end
    end

    always @(posedge clk)
        pt_rddata <= (model_key == good_key) ? good_mem[pt_addr] : bad_mem[pt_addr];

    // second core: length 1, byte 'A' only for good_key2, otherwise 8'h00
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a4_rdy2    <= 1'b0;
            model_key2 <= 24'd0;
        end else if (!a4_rst_n2) begin
            a4_rdy2 <= 1'b0;
        end else if (a4_en2) begin
            model_key2 <= a4_key2;
            a4_rdy2    <= 1'b1;
        end
    end

    always @(posedge clk)
        pt_rddata2 <= (pt_addr2 == 8'd0) ? 8'h01 : ((model_key2 == good_key2) ? 8'h41 : 8'h00);

    always @(negedge clk) begin
        if (clr_mon) begin
            rst_pulses   = 0;
            en_pulses    = 0;
            rst_pulses2  = 0;
            max_addr     = 8'd0;
            max_bad_addr = 8'd0;
        end else begin
            if (!a4_rst_n)  rst_pulses++;
            if (a4_en)      en_pulses++;
            if (!a4_rst_n2) rst_pulses2++;
            if (pt_addr > max_addr) max_addr = pt_addr;
            if (model_key != good_key && pt_addr > max_bad_addr) max_bad_addr = pt_addr;
        end
    end

    task automatic clear_mon();
        clr_mon = 1'b1;
        @(negedge clk);
        @(posedge clk);
        clr_mon = 1'b0;
    endtask

    task automatic start1();
        @(negedge clk);
        h1.en = 1'b1;
        @(negedge clk);
        h1.en = 1'b0;
    endtask

    task automatic start2();
        @(negedge clk);
        h2.en = 1'b1;
        @(negedge clk);
        h2.en = 1'b0;
    endtask

    task automatic wait_rdy(input bit second, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((second ? h2.rdy : h1.rdy) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++; if (h1.rdy !== 1'b1)        begin fails++; $display("[TB] FAIL reset_rdy got %b want 1", h1.rdy); end
        tests_run++; if (h1.key_valid !== 1'b0)  begin fails++; $display("[TB] FAIL reset_key_valid got %b want 0", h1.key_valid); end
        tests_run++; if (h1.key !== 24'd0)       begin fails++; $display("[TB] FAIL reset_key got %h want 0", h1.key); end
        tests_run++; if (a4_rst_n !== 1'b1)      begin fails++; $display("[TB] FAIL reset_a4_rst_n got %b want 1", a4_rst_n); end
        tests_run++; if (a4_en !== 1'b0)         begin fails++; $display("[TB] FAIL reset_a4_en got %b want 0", a4_en); end
        tests_run++; if (a4_key !== 24'd0)       begin fails++; $display("[TB] FAIL reset_a4_key got %h want 0", a4_key); end
        tests_run++; if (pt_addr !== 8'd0)       begin fails++; $display("[TB] FAIL reset_pt_addr got %h want 0", pt_addr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_hello();
        bit ok;
        for (int i = 0; i < 256; i++) begin good_mem[i] = 8'h00; bad_mem[i] = 8'h00; end
        good_key = 24'h000003;
        good_mem[0] = 8'd5;
        good_mem[1] = 8'h48; good_mem[2] = 8'h45; good_mem[3] = 8'h4C; good_mem[4] = 8'h4C; good_mem[5] = 8'h4F;
        bad_mem[0] = 8'd5;
        bad_mem[1] = 8'h7F;
        clear_mon();
        start1();
        wait_rdy(1'b0, 400, ok);
        tests_run++; if (!ok) begin fails++; $display("[TB] FAIL hello_timeout got rdy=%b want 1", h1.rdy); end
        tests_run++; if (h1.key_valid !== 1'b1)  begin fails++; $display("[TB] FAIL hello_key_valid got %b want 1", h1.key_valid); end
        tests_run++; if (h1.key !== 24'h000003)  begin fails++; $display("[TB] FAIL hello_key got %h want 000003", h1.key); end
        tests_run++; if (rst_pulses !== 4)       begin fails++; $display("[TB] FAIL hello_a4_resets got %0d want 4", rst_pulses); end
        tests_run++; if (en_pulses !== 4)        begin fails++; $display("[TB] FAIL hello_a4_starts got %0d want 4", en_pulses); end
        tests_run++; if (max_bad_addr !== 8'd2)  begin fails++; $display("[TB] FAIL hello_bad_addr got %0d want 2", max_bad_addr); end
    endtask

    task automatic test_abort();
        bit ok;
        for (int i = 0; i < 256; i++) begin good_mem[i] = 8'h41; bad_mem[i] = 8'h41; end
        good_key = 24'h000002;
        good_mem[0] = 8'd8; good_mem[1] = 8'h20; good_mem[2] = 8'h7E;
        bad_mem[0]  = 8'd8; bad_mem[1]  = 8'h20; bad_mem[2]  = 8'h1F;
        clear_mon();
        start1();
        wait_rdy(1'b0, 400, ok);
        tests_run++; if (!ok) begin fails++; $display("[TB] FAIL abort_timeout got rdy=%b want 1", h1.rdy); end
        tests_run++; if (max_bad_addr !== 8'd3)  begin fails++; $display("[TB] FAIL abort_last_addr got %0d want 3", max_bad_addr); end
        tests_run++; if (rst_pulses !== 3)       begin fails++; $display("[TB] FAIL abort_a4_resets got %0d want 3", rst_pulses); end
        tests_run++; if (h1.key !== 24'h000002)  begin fails++; $display("[TB] FAIL abort_key got %h want 000002", h1.key); end
        tests_run++; if (h1.key_valid !== 1'b1)  begin fails++; $display("[TB] FAIL abort_key_valid got %b want 1", h1.key_valid); end
    endtask

    task automatic test_len255();
        bit ok;
        for (int i = 0; i < 256; i++) begin good_mem[i] = 8'h7E; bad_mem[i] = 8'h00; end
        good_key = 24'h000000;
        good_mem[0] = 8'hFF;
        clear_mon();
        start1();
        wait_rdy(1'b0, 600, ok);
        tests_run++; if (!ok) begin fails++; $display("[TB] FAIL len255_timeout got rdy=%b want 1", h1.rdy); end
        tests_run++; if (h1.key_valid !== 1'b1)  begin fails++; $display("[TB] FAIL len255_key_valid got %b want 1", h1.key_valid); end
        tests_run++; if (h1.key !== 24'h000000)  begin fails++; $display("[TB] FAIL len255_key got %h want 000000", h1.key); end
        tests_run++; if (max_addr !== 8'hFF)     begin fails++; $display("[TB] FAIL len255_last_addr got %h want ff", max_addr); end
        tests_run++; if (rst_pulses !== 1)       begin fails++; $display("[TB] FAIL len255_a4_resets got %0d want 1", rst_pulses); end
    endtask

    task automatic test_len_zero();
        bit ok;
        for (int i = 0; i < 256; i++) begin good_mem[i] = 8'h41; bad_mem[i] = 8'h00; end
        good_key = 24'h000000;
        good_mem[0] = 8'd0;
        clear_mon();
        start1();
        wait_rdy(1'b0, 100, ok);
        tests_run++; if (!ok) begin fails++; $display("[TB] FAIL len0_timeout got rdy=%b want 1", h1.rdy); end
        tests_run++; if (h1.key_valid !== 1'b1)  begin fails++; $display("[TB] FAIL len0_key_valid got %b want 1", h1.key_valid); end
        tests_run++; if (h1.key !== 24'h000000)  begin fails++; $display("[TB] FAIL len0_key got %h want 000000", h1.key); end
        tests_run++; if (max_addr !== 8'd0)      begin fails++; $display("[TB] FAIL len0_addr got %h want 00", max_addr); end
        tests_run++; if (rst_pulses !== 1)       begin fails++; $display("[TB] FAIL len0_a4_resets got %0d want 1", rst_pulses); end
    endtask

    task automatic test_busy_reset();
        int kv_seen;
        a4_hold = 1'b1;
        clear_mon();
        start1();
        repeat (6) @(negedge clk);
        h1.en = 1'b1;
        repeat (3) @(negedge clk);
        h1.en = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (rst_pulses !== 1)  begin fails++; $display("[TB] FAIL busy_en_resets got %0d want 1", rst_pulses); end
        tests_run++; if (en_pulses !== 1)   begin fails++; $display("[TB] FAIL busy_en_starts got %0d want 1", en_pulses); end
        tests_run++; if (h1.rdy !== 1'b0)   begin fails++; $display("[TB] FAIL busy_rdy got %b want 0", h1.rdy); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (h1.rdy !== 1'b1)   begin fails++; $display("[TB] FAIL midreset_rdy got %b want 1", h1.rdy); end
        tests_run++; if (a4_en !== 1'b0)    begin fails++; $display("[TB] FAIL midreset_a4_en got %b want 0", a4_en); end
        tests_run++; if (a4_rst_n !== 1'b1) begin fails++; $display("[TB] FAIL midreset_a4_rst_n got %b want 1", a4_rst_n); end
        tests_run++; if (a4_key !== 24'd0)  begin fails++; $display("[TB] FAIL midreset_a4_key got %h want 0", a4_key); end
        @(negedge clk);
        rst_n   = 1'b1;
        a4_hold = 1'b0;
        kv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (h1.key_valid !== 1'b0 || h1.rdy !== 1'b1) kv_seen++;
        end
        tests_run++; if (kv_seen !== 0) begin fails++; $display("[TB] FAIL midreset_quiet got %0d busy/valid cycles want 0", kv_seen); end
    endtask

    task automatic test_key_max();
        bit ok;
        good_key2 = 24'hFFFFFF;
        clear_mon();
        start2();
        wait_rdy(1'b1, 200, ok);
        tests_run++; if (!ok) begin fails++; $display("[TB] FAIL keymax_found_timeout got rdy=%b want 1", h2.rdy); end
        tests_run++; if (h2.key_valid !== 1'b1) begin fails++; $display("[TB] FAIL keymax_found_valid got %b want 1", h2.key_valid); end
        tests_run++; if (h2.key !== 24'hFFFFFF) begin fails++; $display("[TB] FAIL keymax_found_key got %h want ffffff", h2.key); end
        good_key2 = 24'h000000;
        clear_mon();
        start2();
        wait_rdy(1'b1, 200, ok);
        tests_run++; if (!ok) begin fails++; $display("[TB] FAIL keymax_none_timeout got rdy=%b want 1", h2.rdy); end
        tests_run++; if (h2.key_valid !== 1'b0) begin fails++; $display("[TB] FAIL keymax_none_valid got %b want 0", h2.key_valid); end
        tests_run++; if (h2.key !== 24'd0)      begin fails++; $display("[TB] FAIL keymax_none_key got %h want 0", h2.key); end
        tests_run++; if (rst_pulses2 !== 2)     begin fails++; $display("[TB] FAIL keymax_attempts got %0d want 2", rst_pulses2); end
        repeat (5) @(negedge clk);
        tests_run++; if (h2.rdy !== 1'b1)       begin fails++; $display("[TB] FAIL keymax_no_wrap got rdy=%b want 1", h2.rdy); end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        rst_n     = 1'b0;
        h1.en     = 1'b0;
        h2.en     = 1'b0;
        a4_hold   = 1'b0;
        clr_mon   = 1'b0;
        good_key  = 24'd0;
        good_key2 = 24'd0;
        for (int i = 0; i < 256; i++) begin good_mem[i] = 8'h00; bad_mem[i] = 8'h00; end
        test_reset();
        test_hello();
        test_abort();
        test_len255();
        test_len_zero();
        test_busy_reset();
        test_key_max();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
